steered_burst_sequencer: RTL

- Successor to the per-channel PWM transmit beamformer.
- Accepts a steering angle through a valid/ready handshake and computes per-element delays sequentially with saturation.
- On `fire`, emits one phase-aligned burst of carrier square-wave cycles per transmitter, then holds off for the echo-listen window.
- Optional auto-repeat mode re-fires continuously. Sits between the angle/scan controller and the transducer drivers.

---
 rtl/steered_burst_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/steered_burst_sequencer.sv
// Transmit beamformer sequencer: latches a steering angle, computes per-element
// delays one channel per cycle, fires phase-aligned carrier bursts, then listens.

module sbs_lane #(
    parameter int TW           = 17,
    parameter int DW           = 16,
    parameter int CARRIER_HALF = 1250,
    parameter int BURST_CYCLES = 20
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic [DW-1:0] d,
    output logic          tx
);
    localparam int PHW = $clog2(2 * CARRIER_HALF);
    localparam int BCW = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;

    logic           run;
    logic [PHW-1:0] ph, cur_ph;
    logic [BCW-1:0] bc, cur_bc;
    logic           act;

    // Phase and period counters replace (t-d) mod period; t passes d exactly once.
    always_comb begin
        cur_ph = run ? ph : '0;
        cur_bc = run ? bc : '0;
        act    = run || (t == TW'(d));
    end

    always_ff @(posedge clk) begin
        if (!rst_in || !en) begin
            run <= 1'b0;
            ph  <= '0;
            bc  <= '0;
            tx  <= 1'b0;
        end else begin
            tx <= act && (cur_ph < PHW'(CARRIER_HALF));
            if (act) begin
                if (cur_ph == PHW'(2 * CARRIER_HALF - 1)) begin
                    ph <= '0;
                    if (cur_bc == BCW'(BURST_CYCLES - 1)) begin
                        run <= 1'b0;
                        bc  <= '0;
                    end else begin
                        run <= 1'b1;
                        bc  <= cur_bc + 1'b1;
                    end
                end else begin
                    run <= 1'b1;
                    ph  <= cur_ph + 1'b1;
                end
            end
        end
    end
endmodule

module steered_burst_sequencer #(
    parameter int NUM_TRANSMITTERS      = 4,
    parameter int SIN_WIDTH             = 16,
    parameter int DELAY_WIDTH           = 16,
    parameter int DELAY_PER_TRANSMITTER = 2623,
    parameter int CARRIER_HALF          = 1250,
    parameter int BURST_CYCLES          = 20,
    parameter int HOLDOFF_CYCLES        = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic [SIN_WIDTH-1:0]        sin_theta,
    input  logic                        sign_bit,
    input  logic                        angle_valid,
    output logic                        angle_ready,
    input  logic                        fire,
    input  logic                        auto_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_TRANSMITTERS-1:0] tx_out
);
    localparam int N         = NUM_TRANSMITTERS;
    localparam int BURST_LEN = 2 * CARRIER_HALF * BURST_CYCLES;
    localparam int CW        = (N > 1) ? $clog2(N) : 1;
    localparam int LW        = $clog2(BURST_LEN + 1);
    localparam int TW        = ((DELAY_WIDTH > LW) ? DELAY_WIDTH : LW) + 1;
    localparam int HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int PW_RAW    = $clog2(DELAY_PER_TRANSMITTER + 1) + CW + SIN_WIDTH;
    // Wide enough that the shifted product always has a bit above DELAY_WIDTH.
    localparam int PW        = (PW_RAW > DELAY_WIDTH + SIN_WIDTH) ? PW_RAW : DELAY_WIDTH + SIN_WIDTH;

    typedef enum logic [1:0] {IDLE, COMPUTE, FIRE, HOLDOFF} state_t;

    state_t                           state, state_n;
    logic [CW-1:0]                    cidx, cidx_n;
    logic [TW-1:0]                    t, t_n;
    logic [HW-1:0]                    hcnt, hcnt_n;
    logic [SIN_WIDTH-1:0]             sin_l;
    logic                             sign_l;
    logic [N-1:0][DELAY_WIDTH-1:0]    delay;
    logic [DELAY_WIDTH-1:0]           dmax;
    logic [CW-1:0]                    k;
    logic [PW-1:0]                    prod, shifted;
    logic [DELAY_WIDTH-1:0]           dsat;
    logic                             take, hold_last_n, fire_en;

    always_comb begin
        k       = sign_l ? CW'(N - 1) - cidx : cidx;
        prod    = PW'(DELAY_PER_TRANSMITTER) * PW'(k) * PW'(sin_l);
        shifted = prod >> (SIN_WIDTH - 1);
        dsat    = (|shifted[PW-1:DELAY_WIDTH]) ? '1 : shifted[DELAY_WIDTH-1:0];
    end

    always_comb begin
        state_n = state;
        cidx_n  = cidx;
        t_n     = t;
        hcnt_n  = hcnt;
        take    = 1'b0;
        case (state)
            IDLE: begin
                take = angle_valid && angle_ready;
                if (fire) begin
                    state_n = COMPUTE;
                    cidx_n  = '0;
                end
            end
            COMPUTE: begin
                cidx_n = cidx + 1'b1;
                if (cidx == CW'(N - 1)) begin
                    state_n = FIRE;
                    t_n     = '0;
                end
            end
            FIRE: begin
                t_n = t + 1'b1;
                if (t == TW'(dmax) + TW'(BURST_LEN - 1)) begin
                    state_n = HOLDOFF;
                    hcnt_n  = '0;
                end
            end
            HOLDOFF: begin
                hcnt_n = hcnt + 1'b1;
                if (hcnt == HW'(HOLDOFF_CYCLES - 1)) begin
                    take    = angle_valid && angle_ready;
                    state_n = auto_in ? COMPUTE : IDLE;
                    cidx_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        hold_last_n = (state_n == HOLDOFF) && (hcnt_n == HW'(HOLDOFF_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state       <= IDLE;
            cidx        <= '0;
            t           <= '0;
            hcnt        <= '0;
            sin_l       <= '0;
            sign_l      <= 1'b0;
            delay       <= '0;
            dmax        <= '0;
            angle_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_n;
            cidx  <= cidx_n;
            t     <= t_n;
            hcnt  <= hcnt_n;
            if (take) begin
                sin_l  <= sin_theta;
                sign_l <= sign_bit;
            end
            if (state == COMPUTE) begin
                delay[cidx] <= dsat;
                dmax        <= (cidx == '0 || dsat > dmax) ? dsat : dmax;
            end
            // Outputs are registered from the next state so they line up with it.
            angle_ready <= (state_n == IDLE) || (hold_last_n && auto_in);
            busy        <= (state_n != IDLE);
            done        <= hold_last_n;
        end
    end

    assign fire_en = (state == FIRE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        sbs_lane #(
            .TW           (TW),
            .DW           (DELAY_WIDTH),
            .CARRIER_HALF (CARRIER_HALF),
            .BURST_CYCLES (BURST_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst_in (rst_in),
            .en     (fire_en),
            .t      (t),
            .d      (delay[i]),
            .tx     (tx_out[i])
        );
    end
endmodule
